// File: rtl/irq_encoder_148_if.sv
// Request/grant bundle between the irq_encoder_148 and its requester/consumer side.
// Carries the active-low request lines, enable and acknowledge into the encoder.
// Carries the active-low grant code, group select, enable-out, valid and pending back out.
interface irq_encoder_148_if;
  logic       not_EI;   // active-low enable; high blocks new grants only
  logic [7:0] not_I;    // active-low async request lines, bit 7 highest priority
  logic       ack;      // consumer acknowledge of the presented grant
  logic [2:0] not_A;    // active-low granted line code
  logic       not_GS;   // active-low group select, low while valid
  logic       not_EO;   // active-low cascade enable-out
  logic       valid;    // grant presented
  logic [7:0] pending;  // pending-request bitmap

  // Requester/consumer side.
  modport master (
    output not_EI, not_I, ack,
    input  not_A, not_GS, not_EO, valid, pending
  );

  // Encoder side.
  modport slave (
    input  not_EI, not_I, ack,
    output not_A, not_GS, not_EO, valid, pending
  );
endinterface

// File: rtl/irq_encoder_148.sv
// 8-line interrupt priority encoder in 74LS148 style with a valid/ack grant handshake.
// Ports: clk, rst (async active-high); bus (slave modport): not_EI, not_I[7:0], ack in;
//        not_A[2:0], not_GS, not_EO, valid, pending[7:0] out.
// Request-to-grant latency is SYNC_STAGES+2 edges; a grant is held until ack, no preemption.
module irq_encoder_148 #(
  parameter int SYNC_STAGES = 2  // flops per request synchroniser, legal range 2..4
) (
  input  logic             clk,
  input  logic             rst,
  irq_encoder_148_if.slave bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  // Synchroniser chain; stage 0 samples the pins, the last stage is the synced value.
  // All stages reset to 1 so a line held low through reset produces a fresh edge.
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  synced;
  logic [7:0]                  prev_q;
  logic [7:0]                  fall;

  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [7:0] clr_mask;
  logic [0:0] state_q;
  logic [2:0] idx_q;
  logic [2:0] top_idx;
  logic       grant_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 8'hFF;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.not_I};
      prev_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  // High-to-low transition of the synced line; held-low lines stop producing this.
  assign fall   = prev_q & ~synced;

  // Highest set pending bit; ascending scan so the last hit is the highest line.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending_q[i]) top_idx = i[2:0];
    end
  end

  // Only an ack against a presented grant clears anything; a same-cycle capture
  // on the granted line is OR'd in afterwards so the new request survives.
  assign grant_ack = (state_q == PRESENT) && bus.ack;
  assign clr_mask  = grant_ack ? (8'h01 << idx_q) : 8'h00;
  assign pending_d = (pending_q & ~clr_mask) | fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 8'h00;
      state_q   <= IDLE;
      idx_q     <= 3'd0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          // Arbitrate on the registered bitmap; not_EI gates only this step.
          if (!bus.not_EI && (pending_q != 8'h00)) begin
            idx_q   <= top_idx;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decoded from registers only (plus not_EI for cascade), so they move
  // only on clk edges or rst.
  assign bus.valid   = (state_q == PRESENT);
  assign bus.not_GS  = ~bus.valid;
  assign bus.not_A   = bus.valid ? ~idx_q : 3'b111;
  assign bus.not_EO  = bus.not_EI | bus.valid | (|pending_q);
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_irq_encoder_148.sv
// Directed self-checking bench for irq_encoder_148 at SYNC_STAGES=2.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-derived from the request/ack timing of the encoder.
module tb_irq_encoder_148;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  irq_encoder_148_if bus_if ();

  irq_encoder_148 #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One rising edge, then settle on the falling edge for drive/sample.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] code);
    chk({tag, "_valid"}, {7'd0, bus_if.valid}, 8'd1);
    chk({tag, "_gs"},    {7'd0, bus_if.not_GS}, 8'd0);
    chk({tag, "_a"},     {5'd0, bus_if.not_A}, {5'd0, code});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {7'd0, bus_if.valid}, 8'd0);
    chk({tag, "_gs"},    {7'd0, bus_if.not_GS}, 8'd1);
    chk({tag, "_a"},     {5'd0, bus_if.not_A}, 8'h07);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst            = 1'b1;
    bus_if.not_I   = 8'hFF;
    bus_if.not_EI  = 1'b0;
    bus_if.ack     = 1'b0;

    // Reset values while reset is held
    #1;
    chk_idle("rst");
    chk("rst_pend", bus_if.pending, 8'h00);
    chk("rst_eo", {7'd0, bus_if.not_EO}, 8'd0);
    steps(2);
    rst = 1'b0;

    // Idle for 20 cycles with no requests
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle_valid", {7'd0, bus_if.valid}, 8'd0);
      chk("idle_pend", bus_if.pending, 8'h00);
    end
    chk_idle("idle_end");
    chk("idle_eo", {7'd0, bus_if.not_EO}, 8'd0);

    // Single request on line 5
    bus_if.not_I = 8'hDF;
    step();
    chk("s5_e1_pend", bus_if.pending, 8'h00);
    step();
    chk("s5_e2_pend", bus_if.pending, 8'h00);
    step();
    chk("s5_e3_pend", bus_if.pending, 8'h20);
    chk("s5_e3_valid", {7'd0, bus_if.valid}, 8'd0);
    chk("s5_e3_eo", {7'd0, bus_if.not_EO}, 8'd1);
    step();
    chk_grant("s5_e4", 3'b010);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk_idle("s5_ack");
    chk("s5_ack_pend", bus_if.pending, 8'h00);
    bus_if.not_I = 8'hFF;
    steps(3);
    chk("s5_rel_pend", bus_if.pending, 8'h00);
    chk("s5_rel_valid", {7'd0, bus_if.valid}, 8'd0);

    // Priority: lines 2 and 6 together, then 7 arrives during the grant
    bus_if.not_I = 8'hBB;
    steps(3);
    chk("pr_pend", bus_if.pending, 8'h44);
    step();
    chk_grant("pr_g6", 3'b001);
    bus_if.not_I = 8'h3B;
    steps(3);
    chk("pr_pend7", bus_if.pending, 8'hC4);
    chk_grant("pr_nopre", 3'b001);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("pr_ack6_valid", {7'd0, bus_if.valid}, 8'd0);
    chk("pr_ack6_pend", bus_if.pending, 8'h84);
    step();
    chk_grant("pr_g7", 3'b000);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("pr_ack7_pend", bus_if.pending, 8'h04);
    step();
    chk_grant("pr_g2", 3'b101);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("pr_ack2_pend", bus_if.pending, 8'h00);
    bus_if.not_I = 8'hFF;
    steps(3);

    // Enable/cascade: line 3 pending with not_EI high
    bus_if.not_EI = 1'b1;
    bus_if.not_I  = 8'hF7;
    steps(5);
    chk("en_pend", bus_if.pending, 8'h08);
    chk("en_valid", {7'd0, bus_if.valid}, 8'd0);
    chk("en_eo", {7'd0, bus_if.not_EO}, 8'd1);
    bus_if.not_EI = 1'b0;
    #1;
    chk("en_eo_low_ei", {7'd0, bus_if.not_EO}, 8'd1);
    step();
    chk_grant("en_g3", 3'b100);
    bus_if.not_EI = 1'b1;
    steps(2);
    chk_grant("en_hold", 3'b100);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("en_ack_valid", {7'd0, bus_if.valid}, 8'd0);
    chk("en_ack_pend", bus_if.pending, 8'h00);
    chk("en_ack_eo", {7'd0, bus_if.not_EO}, 8'd1);
    bus_if.not_EI = 1'b0;
    #1;
    chk("en_eo_idle", {7'd0, bus_if.not_EO}, 8'd0);
    bus_if.not_I = 8'hFF;
    steps(3);

    // Ack in IDLE is ignored
    bus_if.not_EI = 1'b1;
    bus_if.not_I  = 8'hEF;
    steps(3);
    chk("ai_pend", bus_if.pending, 8'h10);
    bus_if.ack = 1'b1;
    steps(2);
    bus_if.ack = 1'b0;
    chk("ai_pend_kept", bus_if.pending, 8'h10);
    chk("ai_valid", {7'd0, bus_if.valid}, 8'd0);

    // Re-assertion edge on line 4 landing in the same cycle as its ack
    bus_if.not_EI = 1'b0;
    step();
    chk_grant("ra_g4", 3'b011);
    bus_if.not_I = 8'hFF;
    steps(2);
    bus_if.not_I = 8'hEF;
    steps(2);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("ra_ack_valid", {7'd0, bus_if.valid}, 8'd0);
    chk("ra_set_wins", bus_if.pending, 8'h10);
    step();
    chk_grant("ra_regrant", 3'b011);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    chk("ra_final_pend", bus_if.pending, 8'h00);
    bus_if.not_I = 8'hFF;
    steps(3);

    // Async reset between edges while line 1 is granted
    bus_if.not_I = 8'hFD;
    steps(4);
    chk_grant("ar_g1", 3'b110);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("ar_imm");
    chk("ar_imm_pend", bus_if.pending, 8'h00);
    #1;
    rst = 1'b0;
    steps(3);
    chk("ar_recap_pend", bus_if.pending, 8'h02);
    chk("ar_recap_valid", {7'd0, bus_if.valid}, 8'd0);
    step();
    chk_grant("ar_regrant", 3'b110);
    bus_if.ack = 1'b1;
    step();
    bus_if.ack = 1'b0;
    bus_if.not_I = 8'hFF;
    chk("ar_ack_pend", bus_if.pending, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
